// File: rtl/avl_stream_rx_fifo.sv
// rtl/avl_stream_rx_fifo.sv - Avalon-ST receive FIFO with framing monitor
// Stores legal beats in a DEPTH-beat FIFO plus output register, drops orphan beats.
module avl_stream_rx_fifo #(
  parameter int WIDTH  = 512,
  parameter int MAX_CH = 4,
  parameter int DEPTH  = 32,
  parameter int AF_TH  = 24,
  localparam int EW = (WIDTH > 8) ? $clog2(WIDTH / 8) : 1,
  localparam int CW = (MAX_CH > 1) ? $clog2(MAX_CH) : 1,
  localparam int OW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [EW-1:0]    in_empty,
  input  logic [CW-1:0]    in_channel,
  output logic             in_almost_full,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sop,
  output logic             out_eop,
  output logic [EW-1:0]    out_empty,
  output logic [CW-1:0]    out_channel,
  output logic [OW-1:0]    occupancy,
  output logic [31:0]      err_cnt,
  output logic [31:0]      drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = WIDTH + EW + CW + 2;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t          state;
  logic [CW-1:0]   pkt_ch;
  logic [BW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [BW-1:0]   out_beat;
  logic [BW-1:0]   in_beat, rd_beat;
  logic            take, store, pop, load, mem_empty, bypass, wr_en;
  logic            err_inc, drop_inc;
  logic [OW-1:0]   occ_next;

  assign take     = in_valid && in_ready;
  assign store    = take && (in_sop || state == IN_PKT);
  assign drop_inc = take && state == IDLE && !in_sop;
  assign err_inc  = drop_inc ||
                    (take && state == IN_PKT && (in_sop || in_channel != pkt_ch));
  assign pop      = out_valid && out_ready;
  assign load     = !out_valid || pop;
  // The output register refills from memory first, so memory can never hold
  // DEPTH beats and equal pointers always mean empty.
  assign mem_empty = (wr_ptr == rd_ptr);
  assign bypass    = load && mem_empty && store;
  assign wr_en     = store && !bypass;

  assign in_beat = {in_sop, in_eop, in_empty, in_channel, in_data};
  assign rd_beat = mem[rd_ptr];
  assign {out_sop, out_eop, out_empty, out_channel, out_data} = out_beat;

  always_comb begin
    occ_next = occupancy;
    if (store && !pop)
      occ_next = occupancy + OW'(1);
    else if (pop && !store)
      occ_next = occupancy - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= in_beat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      out_beat       <= '0;
      out_valid      <= 1'b0;
      occupancy      <= '0;
      in_ready       <= 1'b0;
      in_almost_full <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (load && !mem_empty) begin
        out_beat  <= rd_beat;
        out_valid <= 1'b1;
        rd_ptr    <= rd_ptr + AW'(1);
      end else if (load) begin
        out_valid <= bypass;
        if (bypass)
          out_beat <= in_beat;
      end
      occupancy      <= occ_next;
      in_ready       <= occ_next < OW'(DEPTH);
      in_almost_full <= occ_next >= OW'(AF_TH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pkt_ch   <= '0;
      err_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (store) begin
        if (in_sop)
          pkt_ch <= in_channel;
        state <= in_eop ? IDLE : IN_PKT;
      end
      if (err_inc && err_cnt != 32'hFFFF_FFFF)
        err_cnt <= err_cnt + 32'd1;
      if (drop_inc && drop_cnt != 32'hFFFF_FFFF)
        drop_cnt <= drop_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_avl_stream_rx_fifo.sv
// tb/tb_avl_stream_rx_fifo.sv - scoreboard bench for avl_stream_rx_fifo
module tb_avl_stream_rx_fifo;
  localparam int WIDTH = 512, MAX_CH = 4, DEPTH = 32, AF_TH = 24;
  localparam int EW = 6, CW = 2, OW = 6;

  logic clk = 0, rst_n = 0;
  logic [WIDTH-1:0] in_data = '0, out_data;
  logic in_valid = 0, in_ready, in_sop = 0, in_eop = 0, in_almost_full;
  logic [EW-1:0] in_empty = '0, out_empty;
  logic [CW-1:0] in_channel = '0, out_channel;
  logic out_valid, out_ready = 0, out_sop, out_eop;
  logic [OW-1:0] occupancy;
  logic [31:0] err_cnt, drop_cnt;

  avl_stream_rx_fifo #(.WIDTH(WIDTH), .MAX_CH(MAX_CH), .DEPTH(DEPTH), .AF_TH(AF_TH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty), .in_channel(in_channel),
    .in_almost_full(in_almost_full), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .out_channel(out_channel), .occupancy(occupancy), .err_cnt(err_cnt), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic sop, eop;
    logic [EW-1:0] e;
    logic [CW-1:0] c;
  } beat_t;

  beat_t q[$];
  int n_cmp = 0, n_bad = 0;
  int ready_mode = 1;
  bit arm = 0, mon_en = 0;
  bit m_inpkt = 0;
  logic [CW-1:0] m_ch = '0;
  longint exp_err = 0, exp_drop = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_data();
    logic [WIDTH-1:0] d;
    for (int i = 0; i < WIDTH / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Reference: a packet is open between a sop beat and its eop beat; beats
  // outside a packet without sop are discarded, everything else is kept in order.
  task automatic model(input logic sop, eop, input logic [EW-1:0] e,
                       input logic [CW-1:0] c, input logic [WIDTH-1:0] d);
    beat_t b;
    b.d = d; b.sop = sop; b.eop = eop; b.e = e; b.c = c;
    if (!m_inpkt && !sop) begin
      exp_drop++; exp_err++;
      return;
    end
    if (m_inpkt && sop) exp_err++;
    if (m_inpkt && !sop && c != m_ch) exp_err++;
    if (sop) m_ch = c;
    m_inpkt = !eop;
    q.push_back(b);
  endtask

  task automatic send(input logic sop, eop, input logic [EW-1:0] e, input logic [CW-1:0] c);
    logic [WIDTH-1:0] d;
    bit tk;
    d = rand_data();
    in_sop = sop; in_eop = eop; in_empty = e; in_channel = c; in_data = d; in_valid = 1;
    for (int t = 0; t < 200; t++) begin
      tk = in_ready;
      @(posedge clk); #1;
      if (tk) begin
        model(sop, eop, e, c, d);
        in_valid = 0;
        return;
      end
    end
    in_valid = 0;
    n_cmp++; n_bad++;
    $display("FAIL send_timeout: got in_ready=0 expected accept within 200 cycles");
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 3000 && q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk("drain_left", q.size(), 0);
  endtask

  task automatic set_ready(input int m);
    ready_mode = m;
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 0;
      1: out_ready = 1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    beat_t e;
    if (rst_n && mon_en) begin
      chk("occupancy", occupancy, q.size());
      if (arm) begin
        chk("in_ready", in_ready, q.size() < DEPTH);
        chk("almost_full", in_almost_full, q.size() >= AF_TH);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_beat: got out_valid=1 expected no beat");
        end else begin
          e = q.pop_front();
          n_cmp++;
          if (out_data !== e.d || out_sop !== e.sop || out_eop !== e.eop ||
              out_empty !== e.e || out_channel !== e.c) begin
            n_bad++;
            $display("FAIL beat: got sop=%0b eop=%0b emp=%0d ch=%0d d=%h expected sop=%0b eop=%0b emp=%0d ch=%0d d=%h",
                     out_sop, out_eop, out_empty, out_channel, out_data[63:0],
                     e.sop, e.eop, e.e, e.c, e.d[63:0]);
          end
        end
      end
    end
  end

  initial begin
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_af", in_almost_full, 0);
    chk("rst_sopeop", {out_sop, out_eop}, 0);
    chk("rst_data", out_data[63:0], 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("pre_edge_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("post_edge_ready", in_ready, 1);
    arm = 1; mon_en = 1;

    // single 3-beat packet, channel 2
    send(1, 0, 5, 2);
    chk("latency_valid", out_valid, 1);
    send(0, 0, 5, 2);
    send(0, 1, 5, 2);
    wait_drain();
    chk("t1_err", err_cnt, 0);
    @(posedge clk); #1;
    chk("t1_occ", occupancy, 0);

    // fill with out_ready low
    set_ready(0);
    for (int i = 0; i < DEPTH; i++) begin
      send(1, 1, 6'($urandom), 2'($urandom));
      if (i == AF_TH - 2) chk("af_below", in_almost_full, 0);
      if (i == AF_TH - 1) chk("af_at_th", in_almost_full, 1);
    end
    chk("full_ready", in_ready, 0);
    chk("full_occ", occupancy, DEPTH);
    ready_mode = 1;
    for (int i = 0; i < 8; i++) send(1, 1, 6'($urandom), 2'($urandom));
    wait_drain();

    // orphan beat
    send(0, 1, 0, 1);
    chk("orphan_drop", drop_cnt, 1);
    chk("orphan_err", err_cnt, 1);
    send(1, 0, 0, 1);
    send(0, 1, 3, 1);
    wait_drain();

    // missing eop
    send(1, 0, 0, 0);
    send(0, 0, 0, 0);
    send(1, 0, 0, 3);
    send(0, 1, 1, 3);
    wait_drain();
    chk("noeop_err", err_cnt, 2);

    // channel change mid-packet
    send(1, 0, 0, 1);
    send(0, 0, 0, 3);
    send(0, 1, 2, 1);
    wait_drain();
    chk("chchg_err", err_cnt, 3);
    chk("model_err", err_cnt, exp_err);

    // randomized traffic with random backpressure
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      logic s, eo;
      logic [CW-1:0] c;
      s  = (!m_inpkt) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
      eo = ($urandom_range(0, 3) == 0);
      c  = ($urandom_range(0, 7) == 0 || s) ? 2'($urandom) : m_ch;
      send(s, eo, 6'($urandom), c);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    wait_drain();
    chk("rand_err", err_cnt, exp_err);
    chk("rand_drop", drop_cnt, exp_drop);

    // asynchronous reset with beats stored
    set_ready(0);
    send(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) send(0, 0, 0, 0);
    send(0, 1, 0, 0);
    chk("pre_rst_occ", occupancy, 10);
    @(posedge clk); #3;
    arm = 0; mon_en = 0;
    rst_n = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_err", err_cnt, 0);
    q.delete();
    m_inpkt = 0; exp_err = 0; exp_drop = 0;
    @(posedge clk); #1 rst_n = 1;
    ready_mode = 1;
    @(posedge clk); #1;
    arm = 1; mon_en = 1;
    send(0, 0, 0, 2);
    chk("post_rst_drop", drop_cnt, 1);
    chk("post_rst_occ", occupancy, 0);
    send(1, 1, 4, 2);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/avl_stream_rx_fifo.md
Name: avl_stream_rx_fifo

Overview:
- Receive-side terminator for an Avalon-ST packet stream: acts as the sink for an upstream transmitter and re-drives an Avalon-ST source toward downstream logic.
- Upstream side: accepts beats, stores them in a beat FIFO, and drives ready and almost_full back upstream.
- Downstream side: emits the stored beats in order.
- Framing monitor: checks sop/eop/channel discipline, drops illegal orphan beats, and counts framing errors.
- Placement: between a packet producer (e.g. an Ethernet or DMA stage) and per-packet parsing logic.

Parameters:
- WIDTH, 512, data bus width in bits; a multiple of 8.
- MAX_CH, 4, number of channels; channel width is clog2(MAX_CH).
- DEPTH, 32, FIFO capacity in beats; a power of 2, minimum 4.
- AF_TH, 24, occupancy at or above which in_almost_full is asserted; must be less than DEPTH.

Ports:
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_data, in, WIDTH, upstream beat data.
- in_valid, in, 1, upstream beat valid.
- in_ready, out, 1, block can accept a beat this cycle.
- in_sop, in, 1, start of packet.
- in_eop, in, 1, end of packet.
- in_empty, in, clog2(WIDTH/8), count of unused bytes on an eop beat.
- in_channel, in, clog2(MAX_CH), beat channel.
- in_almost_full, out, 1, occupancy >= AF_TH.
- out_data, out, WIDTH, downstream beat data.
- out_valid, out, 1, downstream beat valid.
- out_ready, in, 1, downstream accepts the beat.
- out_sop, out, 1, start of packet.
- out_eop, out, 1, end of packet.
- out_empty, out, clog2(WIDTH/8), unused bytes.
- out_channel, out, clog2(MAX_CH), channel.
- occupancy, out, clog2(DEPTH)+1, beats currently held.
- err_cnt, out, 32, framing error count; saturating.
- drop_cnt, out, 32, dropped beat count; saturating.

Behaviour:
- Reset (rst_n=0, asynchronous): all pointers, occupancy, err_cnt and drop_cnt go to 0. in_ready=0, in_almost_full=0, out_valid=0, out_sop/out_eop=0, out_data/out_empty/out_channel=0. Framing state goes to IDLE.
- Reset mid-packet discards all stored beats. The first accepted beat after reset must carry sop.
- Leaving reset: in_ready rises on the first clock edge after rst_n deasserts.
- Input handshake, ready latency 0: a beat is taken when in_valid && in_ready.
  - in_ready = (occupancy < DEPTH); registered, and updated on the same edge as occupancy.
  - No pass-through when full: a pop does not create a push slot in the same cycle.
- Framing FSM, IDLE / IN_PKT, evaluated on taken beats only:
  - IDLE, sop=1: store the beat. Latch the channel. If eop=1, stay IDLE; else go to IN_PKT.
  - IDLE, sop=0: drop the beat (not stored). drop_cnt+1, err_cnt+1.
  - IN_PKT, sop=0: store the beat. If its channel differs from the latched channel, err_cnt+1 but the beat is still stored. If eop=1, go to IDLE.
  - IN_PKT, sop=1: store the beat as the start of a new packet. err_cnt+1 (missing eop). Re-latch the channel. Next state follows this beat's eop.
  - in_empty is stored as-is on every beat; the downstream side ignores it when eop=0.
- Storage and output:
  - The FIFO memory is followed by one output register; occupancy counts both.
  - A beat accepted at edge N appears on out_* at edge N+1 at the earliest (1-cycle latency).
  - out_valid stays high and out_* stay stable until out_valid && out_ready.
  - On a pop, the next beat loads in the same cycle; back-to-back throughput is 1 beat/clk.
- occupancy: +1 on a stored push, -1 on a pop, unchanged when both happen. Dropped beats never change occupancy.
- in_almost_full is registered from the next occupancy value. It is advisory only; the upstream side may keep sending until in_ready=0.
- Pointers wrap modulo DEPTH. Simultaneous push and pop at occupancy 1 keeps out_valid=1 with no bubble.
- Counters saturate at 0xFFFFFFFF and never wrap.

Test Plan:
- Reset, then one 3-beat packet on ch 2 (sop on beat 0, eop on beat 2, empty=5), out_ready=1 -> 3 beats out starting 1 cycle after the first accept; sop/eop/empty=5/channel=2 preserved; err_cnt=0, occupancy returns to 0.
- out_ready=0, stream 40 single-beat packets -> in_almost_full=1 when occupancy reaches 24; in_ready=0 at occupancy 32; 32 beats stored; releasing out_ready drains them in order with no loss.
- Orphan beat (sop=0) while IDLE -> not output; drop_cnt=1, err_cnt=1; the following valid packet passes intact.
- Packet A sop with no eop, then packet B sop -> both stored; err_cnt=1; output shows A beats then B beats.
- Mid-packet channel change from 1 to 3 -> beat stored with channel=3; err_cnt=1.
- Assert rst_n=0 asynchronously with 10 beats stored -> out_valid=0 and occupancy=0 immediately; after release, a non-sop beat is dropped with drop_cnt=1.
